// File: rtl/conversor_binario_bcd_seq.sv
// ============================================================================
//  Module      : conversor_binario_bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3, one bit
//                per clock) with start/busy/done handshake and range flag.
//                Optional build macro BCD_SATURATE_EN forces bcd_out to all-9s
//                whenever overflow is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conversor_binario_bcd_seq #(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int FULL_D = (BIN_W + 3) / 3;
    localparam int SCR_W  = 4 * FULL_D;
    localparam int CNT_W  = $clog2(BIN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_last;
    logic [BIN_W-1:0]    r_shreg;
    logic [SCR_W-1:0]    r_scratch;
    logic [SCR_W-1:0]    w_adj;
    logic [SCR_W-1:0]    w_scr_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_bcd;
    logic                w_unused_msb;

    // Add-3 correction on every digit in parallel, evaluated on the pre-shift value
    genvar gi;
    generate
        for (gi = 0; gi < FULL_D; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                      (r_scratch[4*gi +: 4] + 4'd3) :
                                      r_scratch[4*gi +: 4];
        end
    endgenerate

    // FULL_D is sized so the top adjusted bit never carries a value out
    assign w_scr_next   = {w_adj[SCR_W-2:0], r_shreg[BIN_W-1]};
    assign w_unused_msb = w_adj[SCR_W-1];

    generate
        if (DIGITS < FULL_D) begin : g_ovf
            assign w_ovf = |w_scr_next[SCR_W-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

`ifdef BCD_SATURATE_EN
    assign w_bcd = w_ovf ? {DIGITS{4'h9}} : w_scr_next[4*DIGITS-1:0];
`else
    assign w_bcd = w_scr_next[4*DIGITS-1:0];
`endif

    assign w_last = (r_state == SHIFT) && (r_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_next   = SHIFT;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg   <= bin_in;
                r_scratch <= '0;
                r_cnt     <= CNT_W'(BIN_W - 1);
            end else if (r_state == SHIFT) begin
                r_scratch <= w_scr_next;
                r_shreg   <= r_shreg << 1;
                if (!w_last) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            // Outputs move only on the edge that enters DONE
            if (w_last) begin
                bcd_out  <= w_bcd;
                overflow <= w_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conversor_binario_bcd_seq.sv
// ============================================================================
//  Module      : tb_conversor_binario_bcd_seq
//  Description : Self-checking bench for conversor_binario_bcd_seq (default
//                7-bit/2-digit instance plus a 10-bit/3-digit instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_conversor_binario_bcd_seq;

    localparam int BW = 7;
    localparam int DG = 2;
`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  bin_in;
    logic        busy, done, overflow;
    logic [7:0]  bcd_out;

    logic        start2;
    logic [9:0]  bin2;
    logic        busy2, done2, overflow2;
    logic [11:0] bcd2;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    conversor_binario_bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    conversor_binario_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(overflow2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: decimal digits by plain arithmetic
    function automatic logic [15:0] exp_bcd(input int v, input int d);
        int lim;
        int w;
        logic [15:0] r;
        lim = 10 ** d;
        r   = '0;
        if (v >= lim && SAT) begin
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
        end else begin
            w = v % lim;
            for (int i = 0; i < d; i++) begin
                r[4*i +: 4] = 4'(w % 10);
                w = w / 10;
            end
        end
        return r;
    endfunction

    function automatic bit exp_ovf(input int v, input int d);
        return v >= 10 ** d;
    endfunction

    // Cycle-level transaction model: cycles remaining until result, plus held outputs
    int          m_rem = 0;
    int          m_val = 0;
    logic        m_done;
    logic        m_ovf;
    logic [15:0] m_bcd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_bcd  <= '0;
        end else if (m_rem > 0) begin
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_bcd <= exp_bcd(m_val, DG);
                m_ovf <= exp_ovf(m_val, DG);
            end
            m_rem <= m_rem - 1;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_val <= int'(bin_in);
                m_rem <= BW;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cycle {busy,done,ovf,bcd}",
                  {21'd0, busy, done, overflow, bcd_out},
                  {21'd0, (m_rem > 0), m_done, m_ovf, m_bcd[7:0]});
        end
    end

    task automatic run_conv(input int v, output int lat, output int nbusy);
        bit got;
        start  = 1'b1;
        bin_in = 7'(v);
        lat    = 0;
        nbusy  = 0;
        got    = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (busy) nbusy++;
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, nb, ndone, pos[3];
    logic [7:0] vals[3];

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        start2 = 1'b0;
        bin2   = '0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_state", {busy, done, overflow, bcd_out}, 32'd0);
        check("reset_state2", {busy2, done2, overflow2, bcd2}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);

        // 1: 99 -> 0x99, latency and busy length
        run_conv(99, lat, nb);
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", nb, 7);
        check("t1_bcd", bcd_out, 8'h99);
        check("t1_ovf", overflow, 0);
        @(negedge clock);

        // 2: 127 overflows
        run_conv(127, lat, nb);
        check("t2_bcd", bcd_out, SAT ? 8'h99 : 8'h27);
        check("t2_ovf", overflow, 1);
        @(negedge clock);

        // 3: 0 then 10, single-cycle done pulses
        run_conv(0, lat, nb);
        check("t3_bcd0", bcd_out, 8'h00);
        check("t3_ovf0", overflow, 0);
        @(negedge clock);
        check("t3_done_width0", done, 0);
        run_conv(10, lat, nb);
        check("t3_bcd10", bcd_out, 8'h10);
        @(negedge clock);
        check("t3_done_width10", done, 0);

        // 4: start during SHIFT is ignored
        start = 1'b1; bin_in = 7'd45; ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 3) begin start = 1'b1; bin_in = 7'd77; end
            if (done) begin ndone++; vals[0] = bcd_out; end
        end
        check("t4_done_count", ndone, 1);
        check("t4_bcd", vals[0], 8'h45);

        // 5: reset mid-conversion abandons it
        start = 1'b1; bin_in = 7'd88; ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == 3) #1 reset = 1'b1;
            if (k == 4) reset = 1'b0;
            if (done) ndone++;
        end
        check("t5_done_count", ndone, 0);
        check("t5_bcd_after_reset", {overflow, bcd_out}, 0);
        run_conv(12, lat, nb);
        check("t5_bcd12", bcd_out, 8'h12);
        @(negedge clock);

        // 6: start held high, back-to-back conversions
        start = 1'b1; bin_in = 7'd5; ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (k == 1)  bin_in = 7'd60;
            if (k == 9)  bin_in = 7'd99;
            if (k == 17) start = 1'b0;
            if (done) begin
                if (ndone < 3) begin pos[ndone] = k; vals[ndone] = bcd_out; end
                ndone++;
            end
        end
        check("t6_done_count", ndone, 3);
        check("t6_pos0", pos[0], 8);
        check("t6_pos1", pos[1], 16);
        check("t6_pos2", pos[2], 24);
        check("t6_val0", vals[0], 8'h05);
        check("t6_val1", vals[1], 8'h60);
        check("t6_val2", vals[2], 8'h99);

        // 7: 10-bit / 3-digit instance, 1023
        start2 = 1'b1; bin2 = 10'd1023; lat = 0;
        while (!done2 && lat < 40) begin
            @(negedge clock);
            lat++;
            start2 = 1'b0;
        end
        check("t7_latency", lat, 11);
        check("t7_bcd", bcd2, SAT ? 12'h999 : 12'h023);
        check("t7_ovf", overflow2, 1);
        @(negedge clock);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
